// File: rtl/key_debounce_conditioner.sv
// Synchronises and debounces active-low pushbuttons; emits clean levels plus press/release strobes.
// Latency: 2 + DEBOUNCE_CYCLES cycles from a clean raw edge; no backpressure (free-running strobes).
// Optional auto-repeat of key_press while held: define KEY_AUTOREPEAT_EN.
module key_debounce_conditioner #(
  parameter int NUM_KEYS             = 3,
  parameter int DEBOUNCE_CYCLES      = 500000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] key_raw_n,
  output logic [NUM_KEYS-1:0] keys_level_n,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {UP, PRESS_PEND, DOWN, REL_PEND} state_t;

  logic [NUM_KEYS-1:0] sync_q1;
  logic [NUM_KEYS-1:0] sync_q2;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= key_raw_n;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_t          state;
    logic [CW-1:0]   cnt;
    logic            level_q;
    logic            press_q;
    logic            rel_q;
    logic            s;

    assign s = sync_q2[i];

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD_CYCLES - 1);

    logic [RW-1:0] rpt;
    logic          rpt_armed;
    logic          rpt_hit;

    // First repeat waits the long delay, later ones use the short period.
    assign rpt_hit = rpt_armed ? (rpt == PER_LAST) : (rpt == DLY_LAST);
`endif

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        state   <= UP;
        cnt     <= '0;
        level_q <= 1'b1;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rpt       <= '0;
        rpt_armed <= 1'b0;
`endif
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        case (state)
          UP: begin
            if (!s) begin
              state <= PRESS_PEND;
              cnt   <= CW'(1);
            end
          end
          PRESS_PEND: begin
            if (s) begin
              state <= UP;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= DOWN;
              cnt     <= '0;
              level_q <= 1'b0;
              press_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DOWN: begin
            if (s) begin
              state <= REL_PEND;
              cnt   <= CW'(1);
            end
`ifdef KEY_AUTOREPEAT_EN
            else if (rpt_hit) begin
              press_q   <= 1'b1;
              rpt       <= '0;
              rpt_armed <= 1'b1;
            end else begin
              rpt <= rpt + RW'(1);
            end
`endif
          end
          REL_PEND: begin
            if (!s) begin
              state <= DOWN;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state   <= UP;
              cnt     <= '0;
              level_q <= 1'b1;
              rel_q   <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
              rpt       <= '0;
              rpt_armed <= 1'b0;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= UP;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign keys_level_n[i] = level_q;
    assign key_press[i]    = press_q;
    assign key_release[i]  = rel_q;
  end

endmodule
